// File: rtl/fetch_decode_pkg.sv
// rtl/fetch_decode_pkg.sv - IR field positions and fetch/decode state encodings shared with control
package fetch_decode_pkg;

    localparam int IR_INST_HI = 15;
    localparam int IR_INST_LO = 12;
    localparam int IR_FMT_HI  = 11;
    localparam int IR_FMT_LO  = 10;
    localparam int IR_REG0_HI = 9;
    localparam int IR_REG0_LO = 5;
    localparam int IR_REG1_HI = 4;
    localparam int IR_REG1_LO = 0;

    typedef enum logic [1:0] {
        FD_FETCH = 2'd0,
        FD_ISSUE = 2'd1,
        FD_HALT  = 2'd2
    } fd_state_t;

    // Little-endian halfword select within a 32-bit RAM word.
    function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/fetch_decode_ir_split.sv
// rtl/fetch_decode_ir_split.sv - combinational split of a 16-bit IR into its fields
module ir_split
    import fetch_decode_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  inst,
    output logic [1:0]  fmt,
    output logic [4:0]  reg0,
    output logic [4:0]  reg1
);

    assign inst = ir[IR_INST_HI:IR_INST_LO];
    assign fmt  = ir[IR_FMT_HI:IR_FMT_LO];
    assign reg0 = ir[IR_REG0_HI:IR_REG0_LO];
    assign reg1 = ir[IR_REG1_HI:IR_REG1_LO];

endmodule

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - fetch/decode stage: one-word buffer, PC, registered IR decode for control
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    output logic              o_ram_req,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic              i_ram_ack,
    input  logic [31:0]       i_ram_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_ir,
    output logic [3:0]        o_inst,
    output logic [1:0]        o_fmt,
    output logic [4:0]        o_reg0,
    output logic [4:0]        o_reg1,
    output logic [ADDR_W-1:0] o_pc_inc,
    input  logic              i_do_jump,
    input  logic [ADDR_W-1:0] i_pc_jump
);

    localparam logic [ADDR_W-1:0] HALF_MASK = ~ADDR_W'(1);

    fd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc_q, pc_inc_d;
    logic [31:0]       buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic              ram_req_q, ram_req_d;
    logic [15:0]       ir_q, ir_d;
    logic              accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FD_FETCH;
            pc_q        <= RESET_PC & HALF_MASK;
            pc_inc_q    <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            ram_req_q   <= 1'b0;
            ir_q        <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_inc_q    <= pc_inc_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            ram_req_q   <= ram_req_d;
            ir_q        <= ir_d;
        end
    end

    assign accept = o_valid & i_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_inc_d    = pc_inc_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        ram_req_d   = ram_req_q;
        ir_d        = ir_q;
        case (state_q)
            FD_FETCH: begin
                ram_req_d = 1'b1;
                if (ram_req_q && i_ram_ack) begin
                    ram_req_d   = 1'b0;
                    buf_d       = i_ram_data;
                    buf_valid_d = 1'b1;
                    ir_d        = half_sel(i_ram_data, pc_q[1]);
                    pc_inc_d    = pc_q + ADDR_W'(2);
                    state_d     = i_run ? FD_ISSUE : FD_HALT;
                end
            end
            FD_ISSUE: begin
                if (accept) begin
                    // A jump always wins over a still-buffered upper halfword.
                    if (i_do_jump) begin
                        pc_d        = i_pc_jump & HALF_MASK;
                        buf_valid_d = 1'b0;
                        ram_req_d   = 1'b1;
                        state_d     = FD_FETCH;
                    end else if (!pc_q[1]) begin
                        pc_d     = pc_q + ADDR_W'(2);
                        pc_inc_d = pc_q + ADDR_W'(4);
                        ir_d     = buf_q[31:16];
                    end else begin
                        pc_d        = pc_q + ADDR_W'(2);
                        buf_valid_d = 1'b0;
                        ram_req_d   = 1'b1;
                        state_d     = FD_FETCH;
                    end
                    if (!i_run) begin
                        ram_req_d = 1'b0;
                        state_d   = FD_HALT;
                    end
                end
            end
            default: begin
                ram_req_d = 1'b0;
                state_d   = FD_HALT;
            end
        endcase
    end

    assign o_valid    = (state_q == FD_ISSUE) && buf_valid_q;
    assign o_ram_req  = ram_req_q;
    assign o_ram_addr = {pc_q[ADDR_W-1:2], 2'b00};
    assign o_ir       = ir_q;
    assign o_pc_inc   = pc_inc_q;

    ir_split u_ir_split (
        .ir   (ir_q),
        .inst (o_inst),
        .fmt  (o_fmt),
        .reg0 (o_reg0),
        .reg1 (o_reg1)
    );

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed self-checking bench for fetch_decode
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        ram_req;
    logic [31:0] ram_addr;
    logic        ram_ack;
    logic [31:0] ram_data;
    logic        valid;
    logic        ready;
    logic [15:0] ir;
    logic [3:0]  inst;
    logic [1:0]  fmt;
    logic [4:0]  reg0;
    logic [4:0]  reg1;
    logic [31:0] pc_inc;
    logic        do_jump;
    logic [31:0] pc_jump;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    fetch_decode #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_run      (run),
        .o_ram_req  (ram_req),
        .o_ram_addr (ram_addr),
        .i_ram_ack  (ram_ack),
        .i_ram_data (ram_data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_ir       (ir),
        .o_inst     (inst),
        .o_fmt      (fmt),
        .o_reg0     (reg0),
        .o_reg1     (reg1),
        .o_pc_inc   (pc_inc),
        .i_do_jump  (do_jump),
        .i_pc_jump  (pc_jump)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a request, checks its address, acks after dly cycles, checks o_valid one cycle later.
    task automatic serve_fetch(input logic [31:0] addr, input logic [31:0] word, input int dly,
                               input logic exp_valid);
        int n = 0;
        while (!ram_req && n < 20) begin
            tick();
            n++;
        end
        assertions++;
        if (ram_req !== 1'b1) begin
            failures++;
            $display("FAIL fetch_req_timeout: o_ram_req=%b required 1", ram_req);
        end
        assertions++;
        if (ram_addr !== addr) begin
            failures++;
            $display("FAIL fetch_addr: o_ram_addr=%h required %h", ram_addr, addr);
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            assertions++;
            if (ram_req !== 1'b1 || ram_addr !== addr || valid !== 1'b0) begin
                failures++;
                $display("FAIL fetch_hold: req=%b addr=%h valid=%b required 1 %h 0", ram_req, ram_addr, valid, addr);
            end
        end
        ram_ack  = 1'b1;
        ram_data = word;
        tick();
        ram_ack  = 1'b0;
        ram_data = 32'h0;
        assertions++;
        if (valid !== exp_valid || ram_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done: valid=%b req=%b required %b 0", valid, ram_req, exp_valid);
        end
    endtask

    task automatic accept(input logic jump, input logic [31:0] target);
        ready   = 1'b1;
        do_jump = jump;
        pc_jump = target;
        tick();
        ready   = 1'b0;
        do_jump = 1'b0;
        pc_jump = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        assertions++;
        if ({valid, ram_req, ir, inst, fmt, reg0, reg1, pc_inc} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b req=%b ir=%h pc_inc=%h required all 0", valid, ram_req, ir, pc_inc);
        end
        rst = 1'b0;
        tick();
        assertions++;
        if (ram_req !== 1'b1 || ram_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_release_req: req=%b addr=%h required 1 0", ram_req, ram_addr);
        end
    endtask

    task automatic test_first_fetch();
        serve_fetch(32'h0, 32'h5123_4A41, 2, 1'b1);
        assertions++;
        if (ir !== 16'h4A41 || inst !== 4'h4 || fmt !== 2'd2 || reg0 !== 5'h12 || reg1 !== 5'h01 || pc_inc !== 32'h2) begin
            failures++;
            $display("FAIL first_decode: ir=%h inst=%h fmt=%h r0=%h r1=%h pc_inc=%h required 4a41 4 2 12 01 2",
                     ir, inst, fmt, reg0, reg1, pc_inc);
        end
    endtask

    task automatic test_back_to_back();
        accept(1'b0, 32'h0);
        assertions++;
        if (valid !== 1'b1 || ir !== 16'h5123 || inst !== 4'h5 || reg0 !== 5'h09 || reg1 !== 5'h03 ||
            pc_inc !== 32'h4 || ram_req !== 1'b0) begin
            failures++;
            $display("FAIL buffered_hit: valid=%b ir=%h r0=%h r1=%h pc_inc=%h req=%b required 1 5123 09 03 4 0",
                     valid, ir, reg0, reg1, pc_inc, ram_req);
        end
        accept(1'b0, 32'h0);
        assertions++;
        if (valid !== 1'b0 || ram_req !== 1'b1 || ram_addr !== 32'h4) begin
            failures++;
            $display("FAIL next_word_req: valid=%b req=%b addr=%h required 0 1 4", valid, ram_req, ram_addr);
        end
        serve_fetch(32'h4, 32'h9876_0C21, 1, 1'b1);
        assertions++;
        if (ir !== 16'h0C21 || pc_inc !== 32'h6) begin
            failures++;
            $display("FAIL word1_decode: ir=%h pc_inc=%h required 0c21 6", ir, pc_inc);
        end
    endtask

    task automatic test_jump();
        accept(1'b1, 32'h103);
        assertions++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL jump_valid_drop: valid=%b required 0", valid);
        end
        serve_fetch(32'h100, 32'hB2C5_7E0F, 0, 1'b1);
        assertions++;
        if (ir !== 16'hB2C5 || inst !== 4'hB || fmt !== 2'd0 || reg0 !== 5'h16 || reg1 !== 5'h05 || pc_inc !== 32'h104) begin
            failures++;
            $display("FAIL jump_decode: ir=%h inst=%h fmt=%h r0=%h r1=%h pc_inc=%h required b2c5 b 0 16 05 104",
                     ir, inst, fmt, reg0, reg1, pc_inc);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            do_jump = i[0];
            pc_jump = 32'h2000 + 32'(i * 6);
            tick();
            assertions++;
            if (valid !== 1'b1 || ir !== 16'hB2C5 || pc_inc !== 32'h104 || ram_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: valid=%b ir=%h pc_inc=%h req=%b required 1 b2c5 104 0",
                         i, valid, ir, pc_inc, ram_req);
            end
        end
        do_jump = 1'b0;
        pc_jump = 32'h0;
        accept(1'b0, 32'h0);
        assertions++;
        if (ram_req !== 1'b1 || ram_addr !== 32'h104) begin
            failures++;
            $display("FAIL stall_pc_kept: req=%b addr=%h required 1 104", ram_req, ram_addr);
        end
    endtask

    task automatic test_halt();
        run = 1'b0;
        serve_fetch(32'h104, 32'h1111_2222, 2, 1'b0);
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            assertions++;
            if (valid !== 1'b0 || ram_req !== 1'b0) begin
                failures++;
                $display("FAIL halt_persist%0d: valid=%b req=%b required 0 0", i, valid, ram_req);
            end
        end
    endtask

    task automatic test_reset_mid_fetch_and_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        serve_fetch(32'h0, 32'h5123_4A41, 0, 1'b1);
        accept(1'b1, 32'h40);
        assertions++;
        if (ram_req !== 1'b1 || ram_addr !== 32'h40) begin
            failures++;
            $display("FAIL req_at_40: req=%b addr=%h required 1 40", ram_req, ram_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        assertions++;
        if ({valid, ram_req, ir, inst, fmt, reg0, reg1, pc_inc} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: valid=%b req=%b ir=%h pc_inc=%h required all 0", valid, ram_req, ir, pc_inc);
        end
        tick();
        assertions++;
        if (ram_req !== 1'b1 || ram_addr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_refetch: req=%b addr=%h required 1 0", ram_req, ram_addr);
        end
        serve_fetch(32'h0, 32'h5123_4A41, 0, 1'b1);
        accept(1'b1, 32'hFFFF_FFFF);
        serve_fetch(32'hFFFF_FFFC, 32'hC3A5_1234, 1, 1'b1);
        assertions++;
        if (ir !== 16'hC3A5 || pc_inc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_decode: ir=%h pc_inc=%h required c3a5 0", ir, pc_inc);
        end
        accept(1'b0, 32'h0);
        assertions++;
        if (ram_req !== 1'b1 || ram_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_fetch: req=%b addr=%h required 1 0", ram_req, ram_addr);
        end
    endtask

    initial begin
        rst      = 1'b1;
        run      = 1'b1;
        ram_ack  = 1'b0;
        ram_data = 32'h0;
        ready    = 1'b0;
        do_jump  = 1'b0;
        pc_jump  = 32'h0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_jump();
        test_stall();
        test_halt();
        test_reset_mid_fetch_and_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
